// File: rtl/edge_event_detector_if.sv
// Channel bundle between the raw pins and the edge_event_detector:
// input pins, mode and clear controls, plus filtered level, pulse, flags and timestamps.
interface edge_event_detector_if #(
    parameter int unsigned NB_CHANNELS = 10,
    parameter int unsigned TS_WIDTH    = 16
);
    logic [NB_CHANNELS-1:0]          sig_i;
    logic [2*NB_CHANNELS-1:0]        mode_i;
    logic [NB_CHANNELS-1:0]          clear_i;
    logic [NB_CHANNELS-1:0]          level_o;
    logic [NB_CHANNELS-1:0]          edge_pulse_o;
    logic [NB_CHANNELS-1:0]          pending_o;
    logic [NB_CHANNELS-1:0]          overflow_o;
    logic [NB_CHANNELS*TS_WIDTH-1:0] ts_o;

    modport master (
        output sig_i,
        output mode_i,
        output clear_i,
        input  level_o,
        input  edge_pulse_o,
        input  pending_o,
        input  overflow_o,
        input  ts_o
    );

    modport slave (
        input  sig_i,
        input  mode_i,
        input  clear_i,
        output level_o,
        output edge_pulse_o,
        output pending_o,
        output overflow_o,
        output ts_o
    );
endinterface

// File: rtl/edge_event_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter and edge-mode select,
// producing a one-cycle pulse, sticky pending/overflow flags and a timestamp of the first pending edge.
module edge_event_detector #(
    parameter int unsigned NB_CHANNELS = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned TS_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_an_i,
    edge_event_detector_if.slave  bus_if
);

    localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

    logic [TS_WIDTH-1:0] r_tsc;

    // Free-running timestamp counter shared by all channels
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            r_tsc <= '0;
        end else begin
            r_tsc <= r_tsc + TS_WIDTH'(1);
        end
    end

    for (genvar i = 0; i < NB_CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_level;
        logic                   r_pulse;
        logic                   r_pending;
        logic                   r_overflow;
        logic [TS_WIDTH-1:0]    r_ts;

        logic w_s;
        logic w_diff;
        logic w_commit;
        logic w_ev;

        // Commit when the synchronised level has differed for FILT_CYCLES consecutive samples
        always_comb begin
            w_s      = r_sync[SYNC_STAGES-1];
            w_diff   = (w_s != r_level);
            w_commit = w_diff && (r_cnt == CNT_W'(FILT_CYCLES - 1));
            w_ev     = w_commit && ((w_s && bus_if.mode_i[2*i]) ||
                                    (!w_s && bus_if.mode_i[2*i+1]));
        end

        always_ff @(posedge clk_i or negedge rst_an_i) begin
            if (!rst_an_i) begin
                r_sync     <= '0;
                r_cnt      <= '0;
                r_level    <= 1'b0;
                r_pulse    <= 1'b0;
                r_pending  <= 1'b0;
                r_overflow <= 1'b0;
                r_ts       <= '0;
            end else begin
                r_sync  <= {r_sync[SYNC_STAGES-2:0], bus_if.sig_i[i]};
                r_pulse <= w_ev;

                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_level <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end

                // An event wins over a simultaneous clear; a repeat event only flags overflow
                if (w_ev) begin
                    if (!r_pending || bus_if.clear_i[i]) begin
                        r_pending  <= 1'b1;
                        r_overflow <= 1'b0;
                        r_ts       <= r_tsc;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (bus_if.clear_i[i]) begin
                    r_pending  <= 1'b0;
                    r_overflow <= 1'b0;
                end
            end
        end

        assign bus_if.level_o[i]                        = r_level;
        assign bus_if.edge_pulse_o[i]                   = r_pulse;
        assign bus_if.pending_o[i]                      = r_pending;
        assign bus_if.overflow_o[i]                     = r_overflow;
        assign bus_if.ts_o[TS_WIDTH*i +: TS_WIDTH]      = r_ts;
    end

endmodule
